// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3 op codes, controller state encoding and operand-signedness helpers.
package muldiv_pkg;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FINISH,
    S_DONE
  } state_e;

  function automatic logic op_is_div(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic a_is_signed(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic b_is_signed(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Handshake and operand/result bundle between the pipeline controller and the unit.
interface muldiv_if #(
  parameter int N = 32
);
  logic         start;
  logic         flush;
  logic [2:0]   funct3;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic [N-1:0] result;
  logic         busy;
  logic         done;

  modport master (
    output start, flush, funct3, A, B,
    input  result, busy, done
  );

  modport slave (
    input  start, flush, funct3, A, B,
    output result, busy, done
  );
endinterface

// File: rtl/muldiv_datapath.sv
// Operand registers, shared 2N-bit accumulator and the radix-2 step logic.
// Multiply and restoring divide both run on magnitudes; signs are fixed up at finish.
module muldiv_datapath
  import muldiv_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         step_i,
  input  logic         finish_i,
  input  logic [2:0]   funct3_i,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic         special_o,
  output logic         last_o,
  output logic [N-1:0] result_o
);

  localparam int CW = $clog2(N) + 1;

  logic [2:0]     op_q;
  logic [N-1:0]   a_q;
  logic [N-1:0]   b_mag_q;
  logic [2*N-1:0] acc_q;
  logic [2*N-1:0] acc_d;
  logic [CW-1:0]  cnt_q;
  logic           sa_q, sb_q, div0_q, ovf_q;
  logic [N-1:0]   result_q;
  logic [N-1:0]   result_d;

  logic           a_sgn, b_sgn, div0, ovf;
  logic [N-1:0]   a_mag, b_mag;

  assign a_sgn     = a_is_signed(funct3_i) & a_i[N-1];
  assign b_sgn     = b_is_signed(funct3_i) & b_i[N-1];
  assign a_mag     = a_sgn ? (~a_i + 1'b1) : a_i;
  assign b_mag     = b_sgn ? (~b_i + 1'b1) : b_i;
  assign div0      = op_is_div(funct3_i) && (b_i == '0);
  assign ovf       = op_is_div(funct3_i) && b_is_signed(funct3_i)
                     && (a_i == {1'b1, {(N-1){1'b0}}}) && (b_i == '1);
  assign special_o = div0 | ovf;
  assign last_o    = (cnt_q == CW'(1));
  assign result_o  = result_q;

  // Multiply: acc = {partial product, remaining multiplier bits}, shifting right.
  // Divide:   acc = {partial remainder, dividend bits / quotient bits}, shifting left.
  logic [N:0] mul_sum;
  logic [N:0] rem_shift;
  logic [N:0] rem_diff;

  always_comb begin
    acc_d     = acc_q;
    mul_sum   = {1'b0, acc_q[2*N-1:N]} + (acc_q[0] ? {1'b0, b_mag_q} : {(N+1){1'b0}});
    rem_shift = acc_q[2*N-1:N-1];
    rem_diff  = rem_shift - {1'b0, b_mag_q};
    if (op_is_div(op_q)) begin
      if (!rem_diff[N]) begin
        acc_d = {rem_diff[N-1:0], acc_q[N-2:0], 1'b1};
      end else begin
        acc_d = {acc_q[2*N-2:0], 1'b0};
      end
    end else begin
      acc_d = {mul_sum, acc_q[N-1:1]};
    end
  end

  logic [2*N-1:0] prod_fix;
  logic [N-1:0]   quo_fix;
  logic [N-1:0]   rem_fix;

  always_comb begin
    prod_fix = (sa_q ^ sb_q) ? (~acc_q + 1'b1) : acc_q;
    quo_fix  = (sa_q ^ sb_q) ? (~acc_q[N-1:0] + 1'b1) : acc_q[N-1:0];
    rem_fix  = sa_q ? (~acc_q[2*N-1:N] + 1'b1) : acc_q[2*N-1:N];
    case (op_q)
      OP_MUL:                      result_d = prod_fix[N-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: result_d = prod_fix[2*N-1:N];
      OP_DIV, OP_DIVU:             result_d = div0_q ? '1  : (ovf_q ? a_q : quo_fix);
      default:                     result_d = div0_q ? a_q : (ovf_q ? '0  : rem_fix);
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q     <= '0;
      a_q      <= '0;
      b_mag_q  <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      div0_q   <= 1'b0;
      ovf_q    <= 1'b0;
      result_q <= '0;
    end else begin
      if (load_i) begin
        op_q    <= funct3_i;
        a_q     <= a_i;
        b_mag_q <= b_mag;
        acc_q   <= {{N{1'b0}}, a_mag};
        cnt_q   <= CW'(N);
        sa_q    <= a_sgn;
        sb_q    <= b_sgn;
        div0_q  <= div0;
        ovf_q   <= ovf;
      end else if (step_i) begin
        acc_q <= acc_d;
        cnt_q <= cnt_q - CW'(1);
      end
      if (finish_i) begin
        result_q <= result_d;
      end
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: start/busy/done controller around muldiv_datapath.
// Special divide cases skip straight to FINISH; flush aborts CALC/FINISH without a done pulse.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int N = 32
) (
  input  logic     clk,
  input  logic     rst,
  muldiv_if.slave  mdu
);

  state_e state_q;
  state_e state_d;
  logic   load, step, fin;
  logic   special, last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    fin     = 1'b0;
    case (state_q)
      S_IDLE: begin
        // flush outranks a simultaneous start
        if (mdu.start && !mdu.flush) begin
          load    = 1'b1;
          state_d = special ? S_FINISH : S_CALC;
        end
      end
      S_CALC: begin
        if (mdu.flush) begin
          state_d = S_IDLE;
        end else begin
          step = 1'b1;
          if (last) state_d = S_FINISH;
        end
      end
      S_FINISH: begin
        if (mdu.flush) begin
          state_d = S_IDLE;
        end else begin
          fin     = 1'b1;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign mdu.busy = (state_q == S_CALC) || (state_q == S_FINISH);
  assign mdu.done = (state_q == S_DONE);

  muldiv_datapath #(
    .N(N)
  ) u_datapath (
    .clk       (clk),
    .rst       (rst),
    .load_i    (load),
    .step_i    (step),
    .finish_i  (fin),
    .funct3_i  (mdu.funct3),
    .a_i       (mdu.A),
    .b_i       (mdu.B),
    .special_o (special),
    .last_o    (last),
    .result_o  (mdu.result)
  );

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases, randomized ops against an
// arithmetic reference model, start-while-busy, flush and asynchronous reset.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int N = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [31:0] last_res = '0;

  muldiv_if #(.N(N)) mif ();

  muldiv_unit #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .mdu (mif)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [63:0] p;
    int sa, sb;
    sa = a;
    sb = b;
    case (op)
      OP_MUL:    begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      OP_MULH:   begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
      OP_MULHSU: begin p = {{32{a[31]}}, a} * {32'b0, b}; return p[63:32]; end
      OP_MULHU:  begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      OP_DIV: begin
        if (b == 32'h0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return sa / sb;
      end
      OP_DIVU: begin
        if (b == 32'h0) return 32'hFFFF_FFFF;
        return a / b;
      end
      OP_REM: begin
        if (b == 32'h0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return sa % sb;
      end
      default: begin
        if (b == 32'h0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic bit is_fast(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (!op[2]) return 1'b0;
    if (b == 32'h0) return 1'b1;
    return (op == OP_DIV || op == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
  endfunction

  // Issues one op; optionally pokes a second start at cycle poke_cyc (counted from 1 after the start edge).
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int poke_cyc);
    logic [31:0] exp_res;
    int exp_cyc, cyc, busy_cnt;
    bit seen;
    exp_res  = ref_model(op, a, b);
    exp_cyc  = is_fast(op, a, b) ? 2 : N + 2;
    busy_cnt = 0;
    seen     = 1'b0;
    cyc      = 0;
    @(negedge clk);
    mif.start = 1'b1; mif.funct3 = op; mif.A = a; mif.B = b;
    @(negedge clk);
    mif.start = 1'b0;
    for (int c = 1; c <= N + 10; c++) begin
      cyc = c;
      if (mif.busy) busy_cnt++;
      if (mif.done) begin
        seen = 1'b1;
        break;
      end
      if (c == poke_cyc) begin
        mif.start = 1'b1; mif.funct3 = ~op; mif.A = $urandom; mif.B = $urandom;
      end else begin
        mif.start = 1'b0;
      end
      @(negedge clk);
    end
    mif.start = 1'b0;
    check({tag, " done_seen"}, 32'(seen), 32'd1);
    check({tag, " latency"}, 32'(cyc), 32'(exp_cyc));
    check({tag, " busy_cycles"}, 32'(busy_cnt), 32'(exp_cyc - 1));
    check({tag, " result"}, mif.result, exp_res);
    @(negedge clk);
    check({tag, " done_pulse_end"}, 32'(mif.done), 32'd0);
    last_res = exp_res;
    $display("op=%0d A=%h B=%h result=%h expected=%h latency=%0d", op, a, b, mif.result, exp_res, cyc);
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    int          done_cnt;

    mif.start = 1'b0; mif.flush = 1'b0; mif.funct3 = '0; mif.A = '0; mif.B = '0;
    #3;
    check("reset busy", 32'(mif.busy), 32'd0);
    check("reset done", 32'(mif.done), 32'd0);
    check("reset result", mif.result, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    run_op("mul_7_m3", OP_MUL, 32'd7, 32'hFFFF_FFFD, 0);
    check("mul_7_m3 literal", last_res, 32'hFFFF_FFEB);
    run_op("mulhu_ff", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op("mulh_ff", OP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op("mulhsu_m1_2", OP_MULHSU, 32'hFFFF_FFFF, 32'd2, 0);
    run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 0);
    check("div_m7_2 literal", last_res, 32'hFFFF_FFFD);
    run_op("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 0);
    run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 0);
    run_op("remu_100_7", OP_REMU, 32'd100, 32'd7, 0);
    run_op("divu_by0", OP_DIVU, 32'h1234, 32'h0, 0);
    run_op("rem_by0", OP_REM, 32'h1234, 32'h0, 0);
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 0);

    // second start while busy must not disturb the running divide
    run_op("div_poke", OP_DIV, 32'hFFFF_FF00, 32'd9, 5);

    // flush mid-CALC: back to idle, no done, result unchanged
    @(negedge clk);
    mif.start = 1'b1; mif.funct3 = OP_DIV; mif.A = 32'd5000; mif.B = 32'd3;
    @(negedge clk);
    mif.start = 1'b0;
    repeat (9) @(negedge clk);
    check("flush pre busy", 32'(mif.busy), 32'd1);
    mif.flush = 1'b1;
    @(negedge clk);
    mif.flush = 1'b0;
    check("flush busy", 32'(mif.busy), 32'd0);
    done_cnt = 0;
    for (int c = 0; c < N + 8; c++) begin
      if (mif.done || mif.busy) done_cnt++;
      @(negedge clk);
    end
    check("flush no_done", 32'(done_cnt), 32'd0);
    check("flush result_held", mif.result, last_res);

    // flush together with start in IDLE starts nothing
    mif.start = 1'b1; mif.flush = 1'b1; mif.funct3 = OP_MUL; mif.A = 32'd2; mif.B = 32'd2;
    @(negedge clk);
    mif.start = 1'b0; mif.flush = 1'b0;
    check("flush_start busy", 32'(mif.busy), 32'd0);

    // asynchronous reset mid-CALC
    mif.start = 1'b1; mif.funct3 = OP_MUL; mif.A = 32'd1234; mif.B = 32'd77;
    @(negedge clk);
    mif.start = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst busy", 32'(mif.busy), 32'd0);
    check("async_rst done", 32'(mif.done), 32'd0);
    check("async_rst result", mif.result, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    last_res = '0;
    run_op("mul_3_5", OP_MUL, 32'd3, 32'd5, 0);
    check("mul_3_5 literal", last_res, 32'd15);

    // randomized ops, biased toward divide corner cases
    for (int i = 0; i < 24; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'h0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        3: b = {32{b[0]}} | 32'($urandom_range(0, 3));
        default: ;
      endcase
      run_op($sformatf("rand%0d", i), op, a, b, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
